// File: rtl/mmu_ptw_ctrl_if.sv
// mmu_ptw_ctrl_if
// ---------------
// Bundles every non-clock/reset signal of the page-table-walk controller.
// Signal names keep their i_/o_ prefixes, which are given from the walker's point of view.
//
// Modports:
//   master : the walker itself. It drives the memory request, the TLB update
//            and the status outputs, and it receives the miss, memory response
//            and page-table base.
//   slave  : the surrounding system (MMU, memory model, testbench).
//
// Signal groups:
//   miss side   : i_miss, i_missVPN, i_ptbr
//   memory port : o_memReq, o_memAddr, i_memAck, i_memValid, i_memData, i_memErr
//   TLB update  : o_ptwUpdate, o_ptwPTE, o_indexVictim
//   status      : o_busy, o_fault, o_state (walker FSM state, debug only)
//   optional    : o_walkCount, o_faultCount (only when PTW_PERF_CNT_EN is defined)
//
// Handshake rules:
//   - o_memReq/o_memAddr are held stable until the clock edge on which i_memAck is 1.
//     That edge completes the request.
//   - A response beat is transferred on every edge where i_memValid is 1.
//     The walker never stalls beats.
//   - i_memErr is only meaningful on an edge where i_memValid is 1.
interface mmu_ptw_ctrl_if #(
    parameter int ADDR_WIDTH = 35,
    parameter int VPN_WIDTH  = 23,
    parameter int IDX_WIDTH  = 5
);
    logic                  i_miss;
    logic [VPN_WIDTH-1:0]  i_missVPN;
    logic [ADDR_WIDTH-1:0] i_ptbr;

    logic                  o_memReq;
    logic [ADDR_WIDTH-1:0] o_memAddr;
    logic                  i_memAck;
    logic                  i_memValid;
    logic [63:0]           i_memData;
    logic                  i_memErr;

    logic                  o_ptwUpdate;
    logic [63:0]           o_ptwPTE;
    logic [IDX_WIDTH-1:0]  o_indexVictim;

    logic                  o_busy;
    logic                  o_fault;
    logic [1:0]            o_state;

`ifdef PTW_PERF_CNT_EN
    logic [15:0]           o_walkCount;
    logic [15:0]           o_faultCount;
`endif

    modport master (
        input  i_miss, i_missVPN, i_ptbr,
        output o_memReq, o_memAddr,
        input  i_memAck, i_memValid, i_memData, i_memErr,
        output o_ptwUpdate, o_ptwPTE, o_indexVictim,
`ifdef PTW_PERF_CNT_EN
        output o_walkCount, o_faultCount,
`endif
        output o_busy, o_fault, o_state
    );

    modport slave (
        output i_miss, i_missVPN, i_ptbr,
        input  o_memReq, o_memAddr,
        output i_memAck, i_memValid, i_memData, i_memErr,
        input  o_ptwUpdate, o_ptwPTE, o_indexVictim,
`ifdef PTW_PERF_CNT_EN
        input  o_walkCount, o_faultCount,
`endif
        input  o_busy, o_fault, o_state
    );
endinterface

// File: rtl/mmu_ptw_ctrl.sv
// mmu_ptw_ctrl
// ------------
// Page-table-walk controller for MMURCPT TLB misses.
//
// On a miss, the walker performs these steps:
//   1. It fetches an aligned group of PTE_BURST 64-bit PTEs in a single burst.
//      The burst covers the missing VPN.
//   2. It writes every valid PTE (bit0 = 1) into the TLB.
//      Victim slots are chosen round-robin.
//   3. It holds o_busy for HOLDOFF cycles, so the MMU can look up again before
//      another miss is accepted.
//
// A walk fault is reported as a one-cycle o_fault pulse in the first DONE cycle.
// A fault is recorded when either of these happens:
//   - the PTE for the missing VPN itself is invalid, or
//   - any beat returns a memory error.
//
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : mmu_ptw_ctrl_if.master
//             (miss input, memory read port, TLB update, status)
//
// Optional feature:
//   PTW_PERF_CNT_EN : when defined, the walker adds saturating 16-bit counters.
//                     o_walkCount counts walks; o_faultCount counts fault pulses.
module mmu_ptw_ctrl #(
    parameter int ADDR_WIDTH  = 35,
    parameter int VPN_WIDTH   = 23,
    parameter int TLB_ENTRIES = 32,
    parameter int IDX_WIDTH   = 5,
    parameter int PTE_BURST   = 4,
    parameter int HOLDOFF     = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mmu_ptw_ctrl_if.master  bus
);

    // Beat index width. It is kept at least 1 bit wide so that a single-PTE
    // burst still has a legal vector.
    localparam int BEAT_W    = (PTE_BURST > 1) ? $clog2(PTE_BURST) : 1;
    localparam int HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BEAT_W-1:0]     hit_slot;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [IDX_WIDTH-1:0]  victim;
    logic                  err_flag;    // memory error seen in this burst
    logic                  fault_flag;  // fault recorded for this walk

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  ptw_update;
    logic [63:0]           ptw_pte;
    logic [IDX_WIDTH-1:0]  index_victim;
    logic                  busy;
    logic                  fault;

    // ------------------------------------------------------------------
    // Burst geometry for the miss being sampled.
    // The burst base is the missing VPN with its low log2(PTE_BURST) bits
    // cleared. The missing PTE is then at offset hit_slot inside the burst.
    // Only the memory address is kept from the base, so the base is not
    // stored separately.
    // ------------------------------------------------------------------
    logic [VPN_WIDTH-1:0]  miss_base;
    logic [BEAT_W-1:0]     miss_slot;
    logic [ADDR_WIDTH-1:0] req_addr;

    assign miss_base = bus.i_missVPN & ~VPN_WIDTH'(PTE_BURST - 1);
    assign miss_slot = BEAT_W'(bus.i_missVPN) & BEAT_W'(PTE_BURST - 1);
    // Each PTE is 8 bytes. The sum wraps at ADDR_WIDTH.
    assign req_addr  = bus.i_ptbr + ADDR_WIDTH'({miss_base, 3'b000});

    // ------------------------------------------------------------------
    // Per-beat decisions in RESP
    // ------------------------------------------------------------------
    logic beat_write;
    logic beat_fault;
    logic last_beat;
    logic fault_at_done;

    // A beat is written only if all of these hold:
    //   - the PTE is valid (bit0 = 1),
    //   - the beat itself carries no error,
    //   - no earlier beat in the burst errored.
    // After an error, the rest of the burst is drained without writes.
    assign beat_write    = bus.i_memValid && !err_flag && !bus.i_memErr && bus.i_memData[0];
    assign beat_fault    = bus.i_memValid &&
                           (bus.i_memErr || ((beat_cnt == hit_slot) && !bus.i_memData[0]));
    assign last_beat     = bus.i_memValid && (beat_cnt == BEAT_W'(PTE_BURST - 1));
    assign fault_at_done = fault_flag || beat_fault;

    // ------------------------------------------------------------------
    // Walker FSM. All outputs are registered.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            hit_slot     <= '0;
            hold_cnt     <= '0;
            victim       <= '0;
            err_flag     <= 1'b0;
            fault_flag   <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            ptw_update   <= 1'b0;
            ptw_pte      <= '0;
            index_victim <= '0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            ptw_update <= 1'b0;
            fault      <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_miss) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= req_addr;
                        hit_slot <= miss_slot;
                        busy     <= 1'b1;
                    end
                end

                REQ: begin
                    // The request and address stay frozen until they are accepted.
                    if (bus.i_memAck) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                        beat_cnt <= '0;
                    end
                end

                RESP: begin
                    // Cycles without i_memValid are stalls. Nothing advances on them.
                    if (bus.i_memValid) begin
                        beat_cnt   <= beat_cnt + 1'b1;
                        fault_flag <= fault_at_done;
                        if (bus.i_memErr) begin
                            err_flag <= 1'b1;
                        end
                        if (beat_write) begin
                            ptw_update   <= 1'b1;
                            ptw_pte      <= bus.i_memData;
                            index_victim <= victim;
                            // TLB_ENTRIES is a power of two, so the natural
                            // wrap of the index is the round-robin wrap.
                            victim       <= victim + 1'b1;
                        end
                        if (last_beat) begin
                            state    <= DONE;
                            hold_cnt <= '0;
                            fault    <= fault_at_done;
                        end
                    end
                end

                DONE: begin
                    // i_miss is ignored here. This gives the MMU time to re-look
                    // up using the freshly written entries.
                    if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        err_flag   <= 1'b0;
                        fault_flag <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_memReq      = mem_req;
    assign bus.o_memAddr     = mem_addr;
    assign bus.o_ptwUpdate   = ptw_update;
    assign bus.o_ptwPTE      = ptw_pte;
    assign bus.o_indexVictim = index_victim;
    assign bus.o_busy        = busy;
    assign bus.o_fault       = fault;
    assign bus.o_state       = state;

`ifdef PTW_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating walk and fault counters.
    // A walk is counted when the walker enters DONE. A fault is counted on
    // the same edge that raises the o_fault pulse.
    // ------------------------------------------------------------------
    logic [15:0] walk_count;
    logic [15:0] fault_count;
    logic        enter_done;

    assign enter_done = (state == RESP) && last_beat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            walk_count  <= '0;
            fault_count <= '0;
        end else begin
            if (enter_done && (walk_count != 16'hFFFF)) begin
                walk_count <= walk_count + 16'd1;
            end
            if (enter_done && fault_at_done && (fault_count != 16'hFFFF)) begin
                fault_count <= fault_count + 16'd1;
            end
        end
    end

    assign bus.o_walkCount  = walk_count;
    assign bus.o_faultCount = fault_count;
`endif

endmodule

// File: tb/tb_mmu_ptw_ctrl.sv
module tb_mmu_ptw_ctrl;

    localparam int AW      = 35;
    localparam int VW      = 23;
    localparam int IW      = 5;
    localparam int TLB     = 32;
    localparam int BURST   = 4;
    localparam int HOLDOFF = 2;

    // ---------------- clock / reset ----------------
    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    mmu_ptw_ctrl_if #(.ADDR_WIDTH(AW), .VPN_WIDTH(VW), .IDX_WIDTH(IW)) bus ();

    mmu_ptw_ctrl #(
        .ADDR_WIDTH(AW), .VPN_WIDTH(VW), .TLB_ENTRIES(TLB),
        .IDX_WIDTH(IW), .PTE_BURST(BURST), .HOLDOFF(HOLDOFF)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- scoreboard ----------------
    logic [63:0]   exp_pte[$];
    logic [IW-1:0] exp_idx[$];
    logic [63:0]   obs_pte[$];
    logic [IW-1:0] obs_idx[$];
    int            fault_seen = 0;
    int            req_count  = 0;
    logic          prev_req   = 1'b0;

    // Reference state: round-robin pointer and the beats of the next burst
    int            model_victim = 0;
    logic [63:0]   beat_data[BURST];
    bit            beat_err[BURST];

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (bus.o_ptwUpdate === 1'b1) begin
                obs_pte.push_back(bus.o_ptwPTE);
                obs_idx.push_back(bus.o_indexVictim);
            end
            if (bus.o_fault === 1'b1) fault_seen++;
            if (bus.o_memReq === 1'b1 && !prev_req) req_count++;
            prev_req = bus.o_memReq;
        end
    end

    // Reference walk: the list of expected TLB writes and the fault outcome
    function automatic bit model_walk(input logic [VW-1:0] vpn);
        bit err = 0;
        bit flt = 0;
        int hit = int'(vpn) % BURST;
        for (int i = 0; i < BURST; i++) begin
            if (err) continue;
            if (beat_err[i]) begin
                err = 1;
                flt = 1;
            end else if (beat_data[i][0]) begin
                exp_pte.push_back(beat_data[i]);
                exp_idx.push_back(IW'(model_victim));
                model_victim = (model_victim + 1) % TLB;
            end else if (i == hit) begin
                flt = 1;
            end
        end
        return flt;
    endfunction

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] ptbr, input logic [VW-1:0] vpn);
        longint base = (longint'(vpn) / BURST) * BURST;
        return AW'(longint'(ptbr) + base * 8);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        bus.i_miss     = 1'b0;
        bus.i_missVPN  = '0;
        bus.i_memAck   = 1'b0;
        bus.i_memValid = 1'b0;
        bus.i_memData  = '0;
        bus.i_memErr   = 1'b0;
        i_rst_n        = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n      = 1'b1;
        model_victim = 0;
        @(negedge i_clk);
    endtask

    task automatic set_beats(input int invalid_pct, input int err_pct);
        for (int i = 0; i < BURST; i++) begin
            beat_data[i]    = {$urandom, $urandom};
            beat_data[i][0] = ($urandom_range(0, 99) >= invalid_pct);
            beat_err[i]     = ($urandom_range(0, 99) < err_pct);
        end
    endtask

    task automatic run_walk(input logic [VW-1:0] vpn, input int ack_delay,
                            input int gap_min, input int gap_max,
                            input bit toggle_miss, input string name);
        bit            exp_f;
        int            f0;
        int            r0;
        int            n;
        int            g;
        logic [AW-1:0] ea;
        obs_pte.delete(); obs_idx.delete();
        exp_pte.delete(); exp_idx.delete();
        exp_f = model_walk(vpn);
        ea    = model_addr(bus.i_ptbr, vpn);
        f0    = fault_seen;
        r0    = req_count;

        bus.i_miss    = 1'b1;
        bus.i_missVPN = vpn;
        @(negedge i_clk);
        bus.i_miss    = 1'b0;
        for (int k = 0; k <= ack_delay; k++) begin
            vectors++;
            if (bus.o_memReq !== 1'b1 || bus.o_memAddr !== ea) begin
                miscompares++;
                $display("FAIL %s req_hold[%0d]: req=%b addr=%h, expected req=1 addr=%h",
                         name, k, bus.o_memReq, bus.o_memAddr, ea);
            end
            if (k == ack_delay) bus.i_memAck = 1'b1;
            @(negedge i_clk);
        end
        bus.i_memAck = 1'b0;
        vectors++;
        if (bus.o_memReq !== 1'b0) begin
            miscompares++;
            $display("FAIL %s req_drop: req=%b, expected 0", name, bus.o_memReq);
        end

        for (int i = 0; i < BURST; i++) begin
            g = $urandom_range(gap_min, gap_max);
            repeat (g) begin
                bus.i_miss    = toggle_miss ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.i_memData = {$urandom, $urandom};
                bus.i_memErr  = 1'($urandom_range(0, 1));
                @(negedge i_clk);
            end
            bus.i_miss     = 1'b0;
            bus.i_memValid = 1'b1;
            bus.i_memData  = beat_data[i];
            bus.i_memErr   = beat_err[i];
            @(negedge i_clk);
            bus.i_memValid = 1'b0;
            bus.i_memErr   = 1'b0;
        end

        // The last update lands in the first DONE cycle.
        // o_busy then lasts HOLDOFF cycles.
        n = 0;
        while (n < 20 && bus.o_busy === 1'b1) begin
            n++;
            @(negedge i_clk);
        end
        vectors++;
        if (n != HOLDOFF) begin
            miscompares++;
            $display("FAIL %s busy_len: got %0d cycles, expected %0d", name, n, HOLDOFF);
        end
        vectors++;
        if (obs_pte.size() != exp_pte.size()) begin
            miscompares++;
            $display("FAIL %s update_count: got %0d, expected %0d", name, obs_pte.size(), exp_pte.size());
        end
        for (int i = 0; i < obs_pte.size() && i < exp_pte.size(); i++) begin
            vectors++;
            if (obs_pte[i] !== exp_pte[i] || obs_idx[i] !== exp_idx[i]) begin
                miscompares++;
                $display("FAIL %s update[%0d]: pte=%h idx=%0d, expected pte=%h idx=%0d",
                         name, i, obs_pte[i], obs_idx[i], exp_pte[i], exp_idx[i]);
            end
        end
        vectors++;
        if (fault_seen - f0 != int'(exp_f)) begin
            miscompares++;
            $display("FAIL %s fault_pulses: got %0d, expected %0d", name, fault_seen - f0, exp_f);
        end
        vectors++;
        if (req_count - r0 != 1) begin
            miscompares++;
            $display("FAIL %s request_count: got %0d, expected 1", name, req_count - r0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        vectors++;
        if (bus.o_memReq !== 1'b0 || bus.o_memAddr !== '0 || bus.o_ptwUpdate !== 1'b0 ||
            bus.o_ptwPTE !== '0 || bus.o_indexVictim !== '0 || bus.o_busy !== 1'b0 ||
            bus.o_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b addr=%h upd=%b pte=%h idx=%0d busy=%b fault=%b, expected all 0",
                     bus.o_memReq, bus.o_memAddr, bus.o_ptwUpdate, bus.o_ptwPTE,
                     bus.o_indexVictim, bus.o_busy, bus.o_fault);
        end
    endtask

    task automatic test_basic_and_wrap();
        bus.i_ptbr = 35'h1000;
        set_beats(0, 0);
        run_walk(23'h6, 0, 0, 0, 0, "basic");
        set_beats(0, 0);
        run_walk(23'h13, 0, 0, 0, 0, "second");
        // Walks 3..9: walk 8 uses victims 28..31 and walk 9 wraps to 0..3
        for (int w = 3; w <= 9; w++) begin
            set_beats(0, 0);
            run_walk(VW'($urandom), $urandom_range(0, 2), 0, 1, 0, "wrap");
        end
        vectors++;
        if (obs_idx.size() != BURST || obs_idx[0] !== 5'd0 || obs_idx[BURST-1] !== 5'd3) begin
            miscompares++;
            $display("FAIL wrap_victims: walk 9 last idx list size %0d, expected victims 0..3", obs_idx.size());
        end
    endtask

    task automatic test_invalid_target();
        apply_reset();
        bus.i_ptbr = 35'h1000;
        set_beats(0, 0);
        beat_data[2][0] = 1'b0;
        run_walk(23'h6, 0, 0, 0, 0, "invalid_target");
    endtask

    task automatic test_mem_err();
        apply_reset();
        set_beats(0, 0);
        beat_err[1] = 1'b1;
        run_walk(23'h6, 1, 0, 1, 0, "mem_err");
        set_beats(0, 0);
        run_walk(23'h40, 0, 0, 0, 0, "after_err");
    endtask

    task automatic test_stalls();
        set_beats(0, 0);
        run_walk(23'h2b, 5, 3, 3, 1, "stalls");
    endtask

    task automatic test_reset_mid_resp();
        set_beats(0, 0);
        bus.i_miss    = 1'b1;
        bus.i_missVPN = 23'h6;
        @(negedge i_clk);
        bus.i_miss   = 1'b0;
        bus.i_memAck = 1'b1;
        @(negedge i_clk);
        bus.i_memAck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_memValid = 1'b1;
            bus.i_memData  = beat_data[i];
            @(negedge i_clk);
            bus.i_memValid = 1'b0;
        end
        #2 i_rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.o_memReq !== 1'b0 || bus.o_ptwUpdate !== 1'b0 || bus.o_indexVictim !== '0 ||
            bus.o_busy !== 1'b0 || bus.o_fault !== 1'b0 || bus.o_ptwPTE !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: req=%b upd=%b idx=%0d busy=%b fault=%b, expected all 0",
                     bus.o_memReq, bus.o_ptwUpdate, bus.o_indexVictim, bus.o_busy, bus.o_fault);
        end
        @(negedge i_clk);
        i_rst_n      = 1'b1;
        model_victim = 0;
        obs_pte.delete(); obs_idx.delete();
        for (int i = 2; i < BURST; i++) begin
            bus.i_memValid = 1'b1;
            bus.i_memData  = beat_data[i];
            @(negedge i_clk);
            bus.i_memValid = 1'b0;
        end
        repeat (3) @(negedge i_clk);
        vectors++;
        if (obs_pte.size() != 0 || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL leftover_beats: updates=%0d busy=%b, expected 0 updates busy=0",
                     obs_pte.size(), bus.o_busy);
        end
        set_beats(0, 0);
        run_walk(23'h6, 0, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int w = 0; w < 12; w++) begin
            bus.i_ptbr = {AW'($urandom_range(0, 7)), 32'($urandom)} & ~AW'(7);
            set_beats(25, 10);
            run_walk(VW'($urandom), $urandom_range(0, 3), 0, 2, 1, "random");
        end
    endtask

    initial begin
        bus.i_ptbr = '0;
        test_reset();
        test_basic_and_wrap();
        test_invalid_target();
        test_mem_err();
        test_stalls();
        test_reset_mid_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmu_ptw_ctrl.md
Name: mmu_ptw_ctrl

Overview:
Page-table-walk controller that services MMURCPT TLB misses. On a miss it fetches an aligned group of PTEs from memory and writes each valid PTE into the TLB through the ptwUpdate / ptwPTE / indexVictim port, choosing victims round-robin. It sits between MMURCPT and the memory read port and reports walk faults.

Parameters:
ADDR_WIDTH, 35, physical/virtual address width (byte address)
VPN_WIDTH, 23, virtual page number width; page offset = ADDR_WIDTH-VPN_WIDTH = 12
TLB_ENTRIES, 32, TLB entry count (power of 2)
IDX_WIDTH, 5, log2(TLB_ENTRIES)
PTE_BURST, 4, PTEs fetched per walk (power of 2, 1..8)
HOLDOFF, 2, cycles in DONE before a new miss is sampled

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_miss  in  1  MMU lookup missed (level)
i_missVPN  in  VPN_WIDTH  VPN of missed lookup
i_ptbr  in  ADDR_WIDTH  page table base, 8-byte aligned
o_memReq  out  1  memory read request
o_memAddr  out  ADDR_WIDTH  burst start address
i_memAck  in  1  request accepted
i_memValid  in  1  read beat valid (64-bit PTE)
i_memData  in  64  read beat data
i_memErr  in  1  beat error, qualified by i_memValid
o_ptwUpdate  out  1  TLB write strobe (to MMURCPT i_ptwUpdate)
o_ptwPTE  out  64  PTE written (to i_ptwPTE)
o_indexVictim  out  IDX_WIDTH  TLB slot written (to i_indexVictim)
o_busy  out  1  walk in progress
o_fault  out  1  one-cycle walk-fault pulse

Behaviour:
- Reset: state IDLE; all outputs 0; victim pointer 0; beat counter 0; error flag 0.
- States: IDLE, REQ, RESP, DONE.
- IDLE: sample i_miss each edge; on 1 latch vpnBase = i_missVPN with low log2(PTE_BURST) bits cleared, latch hitSlot = i_missVPN low bits, go to REQ. o_busy=0.
- REQ: o_memReq=1, o_memAddr = i_ptbr + vpnBase*8, truncated to ADDR_WIDTH; both held stable until the edge with i_memAck=1, then go to RESP. o_memReq goes high the cycle after the miss is sampled.
- RESP: beats are counted 0..PTE_BURST-1 on i_memValid; non-valid cycles are stalls. For each beat with no error so far and data bit0=1 (PTE valid): next cycle o_ptwUpdate=1 for exactly one cycle, o_ptwPTE=data, o_indexVictim=victim pointer; pointer then increments, wrapping TLB_ENTRIES-1 -> 0. Beats with bit0=0 produce no write and do not advance the pointer.
- Fault conditions: the beat whose index == hitSlot has bit0=0, or any beat has i_memErr=1. After i_memErr, remaining beats of the burst are drained without writes. The erroring beat itself is not written.
- After the last beat, go to DONE. The update registered from the final beat still issues in the first DONE cycle.
- DONE: o_busy=1 for HOLDOFF cycles, letting the MMU re-look up; i_miss is ignored. o_fault pulses one cycle on the first DONE cycle if a fault was recorded. Then go to IDLE and clear the error flag.
- o_busy=1 in REQ, RESP and DONE.
- i_miss outside IDLE is ignored, with no queuing.
- Async reset mid-walk: immediate return to IDLE, outputs 0, victim pointer 0. Beats arriving after reset are ignored in IDLE.

Optional Feature:
PTW_PERF_CNT_EN: when defined, adds outputs o_walkCount[15:0] and o_faultCount[15:0]. They increment on entry to DONE and on each o_fault pulse, saturate at 0xFFFF, and reset to 0. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Basic walk: i_ptbr=0x1000, miss VPN=0x6, PTE_BURST=4 -> o_memAddr=0x1020. Four valid beats produce o_ptwUpdate pulses with o_indexVictim=0,1,2,3 and o_ptwPTE equal to the beats in order; o_fault stays 0; o_busy falls HOLDOFF cycles after the last update.
- Second walk: miss VPN=0x13 -> o_memAddr=0x1080, victims 4..7. Walk 8 uses victims 28..31; walk 9 wraps to victims 0..3.
- Invalid target PTE: VPN=0x6, beat 2 has bit0=0 -> three updates (victims 0,1,2 carrying beats 0,1,3) and one o_fault pulse in DONE.
- Memory error: i_memErr on beat 1 -> only beat 0 written (victim 0); beats 2,3 drained with no writes; o_fault pulses; next walk starts at victim 1.
- Handshake stalls: i_memAck delayed 5 cycles with o_memAddr/o_memReq held stable; gaps of 3 idle cycles between beats; i_miss toggled during RESP -> no second request.
- Reset mid-RESP after 2 beats: outputs 0, victim pointer 0; leftover beats cause no update; a following miss walks normally from victim 0.
